// File: rtl/htp_punch.sv
// HITAC-10 paper-tape punch emulator: accepts CPU bytes, checks parity and queues them for a host drain port.
// Optional HTP_PUNCH_DELAY_EN adds a BUSY state that emulates mechanical punch time.
module htp_punch #(
    parameter int unsigned CH           = 1,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned PUNCH_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            H_DOUT,
    input  logic [3:0]            H_DSEL,
    input  logic                  H_DOPT,
    input  logic [3:0]            H_DREQ,
    output logic [3:0]            H_DRDY,
    output logic [7:0]            pt_data,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [DEPTH_LOG2:0]   pt_count,
    output logic                  pt_perr,
    output logic                  pt_ovf,
    input  logic                  pt_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
`ifdef HTP_PUNCH_DELAY_EN
    localparam int unsigned PW    = (PUNCH_CYCLES > 1) ? $clog2(PUNCH_CYCLES) : 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PARITY = 3'd1,
        S_CHECK  = 3'd2,
`ifdef HTP_PUNCH_DELAY_EN
        S_BUSY   = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t          state;
    logic            dreq;
    logic            dreqd;
    logic            accept;
    logic [7:0]      dbuf;
    logic            opt;
    logic            pflg;
    logic [7:0]      pbit;
    logic            rdy;
`ifdef HTP_PUNCH_DELAY_EN
    logic [PW-1:0]   cnt;
`endif

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   remain;
    logic [CW-1:0]   count_n;
    logic [7:0]      head_n;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            perr_set;
    logic            ovf_set;

    // Only our channel's request line matters; the other bits are ignored.
    logic            unused_dreq;
    assign unused_dreq = ^H_DREQ;

    assign dreq     = H_DREQ[CH];
    assign accept   = (state == S_IDLE) && dreq && !dreqd && (H_DSEL == 4'(CH));
    assign push     = (state == S_CHECK);
    assign perr_set = push && !opt && pflg;
    assign ovf_set  = push && !push_ok;
    assign pt_count = count;

    always_comb begin
        H_DRDY     = '0;
        H_DRDY[CH] = rdy;
    end

    // Fullness is judged after a same-cycle pop so push+pop on a full FIFO succeeds.
    always_comb begin
        pop     = pt_ready && (count != '0);
        remain  = count - CW'(pop);
        push_ok = push && (remain < CW'(DEPTH));
        rd_next = rd_ptr + AW'(pop);
        count_n = remain + CW'(push_ok);
        if (remain == '0) begin
            head_n = push_ok ? dbuf : pt_data;
        end else begin
            head_n = mem[rd_next];
        end
    end

    // Handshake and bit-serial parity FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            dreqd <= 1'b0;
            dbuf  <= '0;
            opt   <= 1'b0;
            pflg  <= 1'b0;
            pbit  <= '0;
            rdy   <= 1'b0;
`ifdef HTP_PUNCH_DELAY_EN
            cnt   <= '0;
`endif
        end else begin
            dreqd <= dreq;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dbuf  <= H_DOUT;
                        opt   <= H_DOPT;
                        pflg  <= 1'b0;
                        pbit  <= 8'h01;
                        state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if ((dbuf & pbit) != 8'h00) begin
                        pflg <= ~pflg;
                    end
                    pbit <= {pbit[6:0], 1'b0};
                    if (pbit[7]) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
`ifdef HTP_PUNCH_DELAY_EN
                    cnt   <= '0;
                    state <= S_BUSY;
`else
                    rdy   <= 1'b1;
                    state <= S_DONE;
`endif
                end
`ifdef HTP_PUNCH_DELAY_EN
                S_BUSY: begin
                    if (cnt == PW'(PUNCH_CYCLES - 1)) begin
                        rdy   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
`endif
                S_DONE: begin
                    if (!dreq) begin
                        rdy   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers, registered head and sticky flags; a set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pt_data  <= '0;
            pt_valid <= 1'b0;
            pt_perr  <= 1'b0;
            pt_ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_next;
            count    <= count_n;
            pt_data  <= head_n;
            pt_valid <= (count_n != '0);
            if (perr_set) begin
                pt_perr <= 1'b1;
            end else if (pt_clr) begin
                pt_perr <= 1'b0;
            end
            if (ovf_set) begin
                pt_ovf <= 1'b1;
            end else if (pt_clr) begin
                pt_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dbuf;
        end
    end

endmodule

// File: tb/tb_htp_punch.sv
// Scoreboard bench for htp_punch: directed CPU transfers, drain port checked by a popping monitor.
module tb_htp_punch;

`ifdef HTP_PUNCH_DELAY_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] H_DOUT;
    logic [3:0] H_DSEL;
    logic       H_DOPT;
    logic [3:0] H_DREQ;
    logic [3:0] H_DRDY;
    logic [7:0] pt_data;
    logic       pt_valid;
    logic       pt_ready;
    logic [2:0] pt_count;
    logic       pt_perr;
    logic       pt_ovf;
    logic       pt_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    htp_punch #(.CH(1), .DEPTH_LOG2(2), .PUNCH_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .H_DOUT(H_DOUT), .H_DSEL(H_DSEL), .H_DOPT(H_DOPT),
        .H_DREQ(H_DREQ), .H_DRDY(H_DRDY),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_count(pt_count), .pt_perr(pt_perr), .pt_ovf(pt_ovf), .pt_clr(pt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full CPU transfer: raise request, wait for ready, drop request, confirm ready falls.
    task automatic xfer(input logic [7:0] d, input logic opt, input logic store);
        int lat;
        H_DOUT = d; H_DOPT = opt; H_DSEL = 4'd1; H_DREQ[1] = 1'b1;
        if (store) exp_q.push_back(d);
        lat = 0;
        while (H_DRDY[1] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk("drdy_latency", 32'(lat), 32'(LAT));
        chk("drdy_bits", 32'(H_DRDY), 32'h2);
        tick();
        chk("drdy_held", 32'(H_DRDY), 32'h2);
        H_DREQ[1] = 1'b0;
        tick();
        chk("drdy_release", 32'(H_DRDY), 32'h0);
    endtask

    task automatic drain();
        pt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pt_count == 3'd0) break;
            tick();
        end
        pt_ready = 1'b0;
        tick();
        chk("drain_count", 32'(pt_count), 32'h0);
        chk("drain_valid", 32'(pt_valid), 32'h0);
    endtask

    // Monitor: every pop must return the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (!reset && pt_valid && pt_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(pt_data), 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", 32'(pt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int lat;
        reset = 1'b1; H_DOUT = '0; H_DSEL = '0; H_DOPT = 1'b0; H_DREQ = '0;
        pt_ready = 1'b0; pt_clr = 1'b0;
        repeat (3) tick();
        chk("rst_drdy",  32'(H_DRDY), 32'h0);
        chk("rst_valid", 32'(pt_valid), 32'h0);
        chk("rst_count", 32'(pt_count), 32'h0);
        chk("rst_perr",  32'(pt_perr), 32'h0);
        chk("rst_ovf",   32'(pt_ovf), 32'h0);
        chk("rst_data",  32'(pt_data), 32'h0);
        reset = 1'b0;
        tick();

        // Basic byte
        xfer(8'h41, 1'b0, 1'b1);
        chk("basic_valid", 32'(pt_valid), 32'h1);
        chk("basic_data",  32'(pt_data), 32'h41);
        chk("basic_count", 32'(pt_count), 32'h1);
        chk("basic_perr",  32'(pt_perr), 32'h0);
        drain();

        // Parity handling
        xfer(8'hC3, 1'b0, 1'b1);
        chk("par_c3_perr", 32'(pt_perr), 32'h0);
        xfer(8'h43, 1'b0, 1'b1);
        chk("par_43_perr", 32'(pt_perr), 32'h1);
        chk("par_43_count", 32'(pt_count), 32'h2);
        pt_clr = 1'b1; tick(); pt_clr = 1'b0;
        chk("par_clr", 32'(pt_perr), 32'h0);
        xfer(8'h43, 1'b1, 1'b1);
        chk("par_bin_perr", 32'(pt_perr), 32'h0);
        chk("par_bin_count", 32'(pt_count), 32'h3);
        drain();

        // Select mismatch, then select fixed while request held
        H_DOUT = 8'h11; H_DSEL = 4'd2; H_DREQ[1] = 1'b1;
        repeat (15) tick();
        chk("sel_drdy", 32'(H_DRDY), 32'h0);
        chk("sel_count", 32'(pt_count), 32'h0);
        H_DSEL = 4'd1;
        repeat (15) tick();
        chk("sel_held_drdy", 32'(H_DRDY), 32'h0);
        chk("sel_held_count", 32'(pt_count), 32'h0);
        H_DREQ[1] = 1'b0;
        tick();
        xfer(8'h11, 1'b0, 1'b1);
        drain();

        // Early request drop: ready pulses for exactly one cycle
        H_DOUT = 8'h3C; H_DOPT = 1'b0; H_DSEL = 4'd1; H_DREQ[1] = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (3) tick();
        H_DREQ[1] = 1'b0;
        lat = 3;
        while (H_DRDY[1] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk("early_latency", 32'(lat), 32'(LAT));
        tick();
        chk("early_pulse", 32'(H_DRDY), 32'h0);
        drain();

        // Overflow: fifth byte dropped, handshake still completes
        xfer(8'h81, 1'b0, 1'b1);
        xfer(8'h82, 1'b0, 1'b1);
        xfer(8'h84, 1'b0, 1'b1);
        xfer(8'h88, 1'b0, 1'b1);
        xfer(8'h90, 1'b0, 1'b0);
        chk("ovf_count", 32'(pt_count), 32'h4);
        chk("ovf_flag",  32'(pt_ovf), 32'h1);
        chk("ovf_perr",  32'(pt_perr), 32'h0);
        pt_clr = 1'b1; tick(); pt_clr = 1'b0;
        chk("ovf_clr", 32'(pt_ovf), 32'h0);

        // Full plus pop in the CHECK cycle
        H_DOUT = 8'hA0; H_DOPT = 1'b0; H_DSEL = 4'd1; H_DREQ[1] = 1'b1;
        exp_q.push_back(8'hA0);
        repeat (9) tick();
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        lat = 10;
        while (H_DRDY[1] !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk("fullpop_latency", 32'(lat), 32'(LAT));
        chk("fullpop_count", 32'(pt_count), 32'h4);
        chk("fullpop_ovf", 32'(pt_ovf), 32'h0);
        chk("fullpop_head", 32'(pt_data), 32'h82);
        H_DREQ[1] = 1'b0;
        tick();
        drain();

        // Reset during PARITY discards the byte
        H_DOUT = 8'h55; H_DSEL = 4'd1; H_DREQ[1] = 1'b1;
        repeat (4) tick();
        reset = 1'b1; H_DREQ[1] = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrst_drdy", 32'(H_DRDY), 32'h0);
        chk("midrst_count", 32'(pt_count), 32'h0);
        repeat (12) tick();
        chk("midrst_idle_drdy", 32'(H_DRDY), 32'h0);
        chk("midrst_idle_count", 32'(pt_count), 32'h0);
        xfer(8'h12, 1'b0, 1'b1);
        chk("post_rst_data", 32'(pt_data), 32'h12);
        drain();

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
